// File: rtl/cpu_pkg.sv
// Shared CPU definitions: R-type funct codes used by the multiply/divide unit,
// its state encoding and default datapath width.
package cpu_pkg;
  localparam int DATA_W_DEF = 32;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} mdu_state_t;

  // Any funct that touches HI/LO and therefore must wait for an iteration.
  function automatic logic is_mdu_fn(input logic [5:0] f);
    return (f == FN_MFHI) || (f == FN_MTHI) || (f == FN_MFLO) || (f == FN_MTLO) ||
           (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
  endfunction
endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-side view of the multiply/divide unit: operands in, stall/HI/LO out.
interface ex_muldiv_unit_if #(parameter int DATA_W = 32);
  logic              op_valid;
  logic [5:0]        funct_in;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              stall;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;
  logic [DATA_W-1:0] mf_data;

  modport master (output op_valid, funct_in, rs_data, rt_data,
                  input  stall, busy, done, hi_out, lo_out, mf_data);
  modport slave  (input  op_valid, funct_in, rs_data, rt_data,
                  output stall, busy, done, hi_out, lo_out, mf_data);
endinterface

// File: rtl/mdu_iter_core.sv
// Unsigned radix-2 iteration engine: shift-add multiply or restoring divide,
// one step per cycle on a shared 2*DATA_W register {hi, lo}.
module mdu_iter_core
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                is_div,
  input  logic [DATA_W-1:0]   a_mag,
  input  logic [DATA_W-1:0]   b_mag,
  output logic                done,
  output logic [2*DATA_W-1:0] acc
);
  logic [CNT_W-1:0]    cnt;
  logic                run;
  logic                div_mode;
  logic [DATA_W-1:0]   opnd_b;
  logic [2*DATA_W-1:0] acc_q;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     rem_try;
  logic [DATA_W:0]     rem_sub;
  logic [2*DATA_W-1:0] step_val;

  // Multiply: add multiplicand into the upper half when the current LSB is set,
  // then shift right with the carry. Divide: shift remainder left, trial-subtract.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_b} : '0);
    rem_try = acc_q[2*DATA_W-1:DATA_W-1];
    rem_sub = rem_try - {1'b0, opnd_b};
    if (!div_mode)
      step_val = {mul_sum, acc_q[DATA_W-1:1]};
    else if (!rem_sub[DATA_W])
      step_val = {rem_sub[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
    else
      step_val = {rem_try[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
  end

  assign done = run && (cnt == CNT_W'(DATA_W - 1));
  assign acc  = acc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      run      <= 1'b0;
      div_mode <= 1'b0;
      opnd_b   <= '0;
      acc_q    <= '0;
    end else if (start) begin
      cnt      <= '0;
      run      <= 1'b1;
      div_mode <= is_div;
      opnd_b   <= b_mag;
      acc_q    <= {{DATA_W{1'b0}}, a_mag};
    end else if (run) begin
      acc_q <= step_val;
      cnt   <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end
endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, sequences MULT/DIV through the
// iteration core, applies sign fix-up and raises stall for dependent ops.
module ex_muldiv_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  ex_muldiv_unit_if.slave mdu
);
  mdu_state_t          state, state_nxt;
  logic [DATA_W-1:0]   hi_q, lo_q, rs_hold;
  logic                neg_p, neg_r, div_op, dz;
  logic                busy_q, done_q;
  logic                idle, fn_mul, fn_div, fn_sgn, acc_mul, acc_div;
  logic                neg_a, neg_b;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic                core_done;
  logic [2*DATA_W-1:0] core_acc, prod_fix;
  logic [DATA_W-1:0]   quo, rem;

  assign idle    = (state == ST_IDLE);
  assign fn_mul  = (mdu.funct_in == FN_MULT) || (mdu.funct_in == FN_MULTU);
  assign fn_div  = (mdu.funct_in == FN_DIV)  || (mdu.funct_in == FN_DIVU);
  assign fn_sgn  = (mdu.funct_in == FN_MULT) || (mdu.funct_in == FN_DIV);
  assign acc_mul = mdu.op_valid && idle && fn_mul;
  assign acc_div = mdu.op_valid && idle && fn_div;

  assign neg_a = fn_sgn && mdu.rs_data[DATA_W-1];
  assign neg_b = fn_sgn && mdu.rt_data[DATA_W-1];
  assign a_mag = neg_a ? -mdu.rs_data : mdu.rs_data;
  assign b_mag = neg_b ? -mdu.rt_data : mdu.rt_data;

  mdu_iter_core #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (acc_mul || acc_div),
    .is_div (acc_div),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .done   (core_done),
    .acc    (core_acc)
  );

  assign prod_fix = neg_p ? -core_acc : core_acc;
  assign quo      = core_acc[DATA_W-1:0];
  assign rem      = core_acc[2*DATA_W-1:DATA_W];

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:        if (acc_mul) state_nxt = ST_MUL;
                      else if (acc_div) state_nxt = ST_DIV;
      ST_MUL, ST_DIV: if (core_done) state_nxt = ST_FIX;
      ST_FIX:         state_nxt = ST_IDLE;
      default:        state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q    <= '0;
      lo_q    <= '0;
      rs_hold <= '0;
      neg_p   <= 1'b0;
      neg_r   <= 1'b0;
      div_op  <= 1'b0;
      dz      <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      busy_q <= (state_nxt != ST_IDLE);
      done_q <= (state == ST_FIX);
      if (acc_mul || acc_div) begin
        neg_p   <= neg_a ^ neg_b;
        neg_r   <= neg_a;
        div_op  <= acc_div;
        dz      <= acc_div && (mdu.rt_data == '0);
        rs_hold <= mdu.rs_data;
      end
      if (state == ST_FIX) begin
        // Divide-by-zero skips sign fix-up: LO all ones, HI the raw dividend.
        if (div_op && dz) begin
          hi_q <= rs_hold;
          lo_q <= '1;
        end else if (div_op) begin
          hi_q <= neg_r ? -rem : rem;
          lo_q <= neg_p ? -quo : quo;
        end else begin
          {hi_q, lo_q} <= prod_fix;
        end
      end else if (idle && mdu.op_valid) begin
        if (mdu.funct_in == FN_MTHI) hi_q <= mdu.rs_data;
        if (mdu.funct_in == FN_MTLO) lo_q <= mdu.rs_data;
      end
    end
  end

  assign mdu.stall   = mdu.op_valid && busy_q && is_mdu_fn(mdu.funct_in);
  assign mdu.busy    = busy_q;
  assign mdu.done    = done_q;
  assign mdu.hi_out  = hi_q;
  assign mdu.lo_out  = lo_q;
  assign mdu.mf_data = (mdu.funct_in == FN_MFHI) ? hi_q :
                       (mdu.funct_in == FN_MFLO) ? lo_q : '0;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: vector table of MULT/DIV results plus
// hand-written stall, MT/MF and mid-iteration reset sequences.
module tb_ex_muldiv_unit;
  import cpu_pkg::*;

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total  = 0;
  vec_t vecs[10];

  ex_muldiv_unit_if #(.DATA_W(32)) bus ();

  ex_muldiv_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mdu   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int busy_n, done_n;
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.funct_in = v.funct;
    bus.rs_data  = v.rs;
    bus.rt_data  = v.rt;
    #1 check({tag, " stall"}, 64'(bus.stall), 64'd0);
    @(negedge clk);
    bus.op_valid = 1'b0;
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) busy_n++;
      if (bus.done) done_n++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, 64'(busy_n), 64'd33);
    check({tag, " done_pulses"}, 64'(done_n), 64'd1);
    check({tag, " hi"}, 64'(bus.hi_out), 64'(v.exp_hi));
    check({tag, " lo"}, 64'(bus.lo_out), 64'(v.exp_lo));
  endtask

  initial begin
    int stall_bad, stall_cyc, seen_idle, done_n;

    vecs[0] = '{FN_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{FN_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{FN_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
    vecs[4] = '{FN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{FN_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[6] = '{FN_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7] = '{FN_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8] = '{FN_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[9] = '{FN_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};

    bus.op_valid = 1'b0;
    bus.funct_in = '0;
    bus.rs_data  = '0;
    bus.rt_data  = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset hi", 64'(bus.hi_out), 64'd0);
    check("reset lo", 64'(bus.lo_out), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Dependent MFHI held against a running MULTU; ADD overlaps freely.
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.funct_in = FN_MULTU;
    bus.rs_data  = 32'hFFFF_FFFF;
    bus.rt_data  = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.funct_in = 6'h20;
    #1 check("add during busy stall", 64'(bus.stall), 64'd0);
    check("add during busy busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    bus.funct_in = FN_MFHI;
    stall_bad = 0;
    stall_cyc = 0;
    seen_idle = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus.busy) begin
        if (!bus.stall) stall_bad++;
        stall_cyc++;
      end else begin
        check("mfhi release stall", 64'(bus.stall), 64'd0);
        check("mfhi release data", 64'(bus.mf_data), 64'hFFFF_FFFE);
        seen_idle = 1;
        break;
      end
      @(negedge clk);
    end
    check("mfhi busy ended", 64'(seen_idle), 64'd1);
    check("mfhi stall missing", 64'(stall_bad), 64'd0);
    check("mfhi stall cycles", 64'(stall_cyc), 64'd32);
    @(negedge clk);
    bus.op_valid = 1'b0;

    // MTLO/MTHI in idle followed by reads.
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.funct_in = FN_MTLO;
    bus.rs_data  = 32'h1234_5678;
    @(negedge clk);
    bus.funct_in = FN_MFLO;
    #1 check("mtlo mf_data", 64'(bus.mf_data), 64'h1234_5678);
    check("mtlo lo_out", 64'(bus.lo_out), 64'h1234_5678);
    check("mtlo no busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    bus.funct_in = FN_MTHI;
    bus.rs_data  = 32'hA5A5_5A5A;
    @(negedge clk);
    bus.funct_in = FN_MFHI;
    #1 check("mthi mf_data", 64'(bus.mf_data), 64'hA5A5_5A5A);
    check("mthi no done", 64'(bus.done), 64'd0);
    bus.funct_in = 6'h20;
    #1 check("other funct mf_data", 64'(bus.mf_data), 64'd0);
    @(negedge clk);
    bus.op_valid = 1'b0;

    // Reset during a divide aborts it with HI/LO cleared and no done pulse.
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.funct_in = FN_DIVU;
    bus.rs_data  = 32'd1000;
    bus.rt_data  = 32'd3;
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort hi", 64'(bus.hi_out), 64'd0);
    check("abort lo", 64'(bus.lo_out), 64'd0);
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done || bus.busy) done_n++;
      @(negedge clk);
    end
    check("abort no activity", 64'(done_n), 64'd0);
    run_vec("post-reset mult", '{FN_MULT, 32'd3, 32'd4, 32'd0, 32'd12});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
